// File: rtl/night_phase_gen.sv
// rtl/night_phase_gen.sv - LDR debounce, day/night decision and night phase sequencer (optional TD_OVERRIDE_EN)
module night_phase_gen #(
    parameter int DEBOUNCE        = 4,
    parameter int TICKS_PER_PHASE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] ldr,
`ifdef TD_OVERRIDE_EN
    input  logic       ovr_en,
    input  logic [1:0] ovr_td,
`endif
    output logic [2:0] day,
    output logic [1:0] TD,
    output logic       night,
    output logic       phase_pulse
);

    localparam int PW = (TICKS_PER_PHASE > 1) ? $clog2(TICKS_PER_PHASE) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICKS_PER_PHASE - 1);
    localparam logic [3:0]    DB_FULL   = 4'(DEBOUNCE);

    typedef enum logic [1:0] {
        DAY        = 2'd0,
        NIGHT_RUN  = 2'd1,
        NIGHT_HOLD = 2'd2
    } state_t;

    state_t        state;
    logic [2:0]    cand;
    logic [3:0]    dcnt;
    logic [PW-1:0] pcnt;
    logic [1:0]    td_q;
    logic          pulse_q;
    logic          daylight;

    assign daylight = (day == 3'b111);

    // Debounce: a new sensor pattern must be seen on DEBOUNCE consecutive ticks before day follows it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand <= 3'b111;
            dcnt <= DB_FULL;
            day  <= 3'b111;
        end else if (tick) begin
            if (ldr != cand) begin
                cand <= ldr;
                dcnt <= 4'd1;
            end else if (dcnt < DB_FULL) begin
                dcnt <= dcnt + 4'd1;
                if (dcnt + 4'd1 == DB_FULL) begin
                    day <= cand;
                end
            end
        end
    end

    // Day/night FSM with phase counter; dawn wins over a coincident phase advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DAY;
            td_q    <= 2'b00;
            night   <= 1'b0;
            pcnt    <= '0;
            pulse_q <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state)
                DAY: begin
                    if (!daylight) begin
                        state <= NIGHT_RUN;
                        night <= 1'b1;
                        td_q  <= 2'b00;
                        pcnt  <= '0;
                    end
                end
                NIGHT_RUN: begin
                    if (daylight) begin
                        state <= DAY;
                        night <= 1'b0;
                        td_q  <= 2'b00;
                        pcnt  <= '0;
                    end else if (tick) begin
                        if (pcnt == PCNT_LAST) begin
                            pcnt    <= '0;
                            td_q    <= td_q + 2'd1;
                            pulse_q <= 1'b1;
                            if (td_q == 2'd2) begin
                                state <= NIGHT_HOLD;
                            end
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                    end
                end
                NIGHT_HOLD: begin
                    if (daylight) begin
                        state <= DAY;
                        night <= 1'b0;
                        td_q  <= 2'b00;
                        pcnt  <= '0;
                    end
                end
                default: begin
                    state <= DAY;
                    night <= 1'b0;
                    td_q  <= 2'b00;
                    pcnt  <= '0;
                end
            endcase
        end
    end

`ifdef TD_OVERRIDE_EN
    logic       ovr_q;
    logic [1:0] ovr_td_q;

    // Maintenance override is registered so TD stays free of input-to-output paths
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovr_q    <= 1'b0;
            ovr_td_q <= 2'b00;
        end else begin
            ovr_q    <= ovr_en;
            ovr_td_q <= ovr_td;
        end
    end

    assign TD          = ovr_q ? ovr_td_q : td_q;
    assign phase_pulse = pulse_q & ~ovr_q;
`else
    assign TD          = td_q;
    assign phase_pulse = pulse_q;
`endif

endmodule

// File: tb/tb_night_phase_gen.sv
// tb/tb_night_phase_gen.sv - directed self-checking bench for night_phase_gen
module tb_night_phase_gen;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [2:0] ldr;
    logic [2:0] day;
    logic [1:0] TD;
    logic       night;
    logic       phase_pulse;
`ifdef TD_OVERRIDE_EN
    logic       ovr_en;
    logic [1:0] ovr_td;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    night_phase_gen #(
        .DEBOUNCE        (4),
        .TICKS_PER_PHASE (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .ldr         (ldr),
`ifdef TD_OVERRIDE_EN
        .ovr_en      (ovr_en),
        .ovr_td      (ovr_td),
`endif
        .day         (day),
        .TD          (TD),
        .night       (night),
        .phase_pulse (phase_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dusk();
        ldr = 3'b101;
        repeat (3) begin
            step();
            chk("dusk_day_hold", 8'(day), 8'h7);
        end
        step();
        chk("dusk_day_new", 8'(day), 8'h5);
        chk("dusk_night_lag", 8'(night), 8'h0);
        step();
        chk("dusk_night", 8'(night), 8'h1);
        chk("dusk_td", 8'(TD), 8'h0);
    endtask

    task automatic phase_expect(input logic [1:0] prev, input logic [1:0] nxt);
        repeat (7) begin
            step();
            chk("phase_td_hold", 8'(TD), 8'(prev));
            chk("phase_no_pulse", 8'(phase_pulse), 8'h0);
        end
        step();
        chk("phase_td_adv", 8'(TD), 8'(nxt));
        chk("phase_pulse", 8'(phase_pulse), 8'h1);
    endtask

    initial begin
        rst  = 1'b0;
        tick = 1'b1;
        ldr  = 3'b000;
`ifdef TD_OVERRIDE_EN
        ovr_en = 1'b0;
        ovr_td = 2'b00;
`endif
        repeat (3) step();
        chk("rst_day", 8'(day), 8'h7);
        chk("rst_td", 8'(TD), 8'h0);
        chk("rst_night", 8'(night), 8'h0);
        chk("rst_pulse", 8'(phase_pulse), 8'h0);

        rst = 1'b1;
        ldr = 3'b111;
        repeat (20) begin
            step();
            chk("idle_day", 8'(day), 8'h7);
            chk("idle_night", 8'(night), 8'h0);
            chk("idle_td", 8'(TD), 8'h0);
        end

        ldr = 3'b101;
        repeat (3) begin
            step();
            chk("glitch_day", 8'(day), 8'h7);
        end
        ldr = 3'b111;
        repeat (6) begin
            step();
            chk("glitch_day_after", 8'(day), 8'h7);
            chk("glitch_night", 8'(night), 8'h0);
            chk("glitch_td", 8'(TD), 8'h0);
        end

        dusk();
        phase_expect(2'd0, 2'd1);

        tick = 1'b0;
        repeat (50) begin
            step();
            chk("gate_td", 8'(TD), 8'h1);
            chk("gate_pulse", 8'(phase_pulse), 8'h0);
        end
        tick = 1'b1;
        phase_expect(2'd1, 2'd2);
        phase_expect(2'd2, 2'd3);
        repeat (100) begin
            step();
            chk("hold_td", 8'(TD), 8'h3);
            chk("hold_pulse", 8'(phase_pulse), 8'h0);
        end

        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_day", 8'(day), 8'h7);
        chk("arst_td", 8'(TD), 8'h0);
        chk("arst_night", 8'(night), 8'h0);
        chk("arst_pulse", 8'(phase_pulse), 8'h0);
        step();
        rst = 1'b1;

        dusk();
        phase_expect(2'd0, 2'd1);
        phase_expect(2'd1, 2'd2);
        repeat (3) begin
            step();
            chk("dawn_pre_td", 8'(TD), 8'h2);
        end
        ldr = 3'b111;
        repeat (3) begin
            step();
            chk("dawn_day_hold", 8'(day), 8'h5);
            chk("dawn_td_hold", 8'(TD), 8'h2);
        end
        step();
        chk("dawn_day", 8'(day), 8'h7);
        chk("dawn_night_lag", 8'(night), 8'h1);
        chk("dawn_td_lag", 8'(TD), 8'h2);
        step();
        chk("dawn_td", 8'(TD), 8'h0);
        chk("dawn_night", 8'(night), 8'h0);
        chk("dawn_no_pulse", 8'(phase_pulse), 8'h0);
        step();
        chk("dawn_no_pulse2", 8'(phase_pulse), 8'h0);
        chk("dawn_td2", 8'(TD), 8'h0);

`ifdef TD_OVERRIDE_EN
        ovr_en = 1'b1;
        ovr_td = 2'b10;
        step();
        chk("ovr_td", 8'(TD), 8'h2);
        ovr_en = 1'b0;
        step();
        chk("ovr_release", 8'(TD), 8'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/night_phase_gen.md
Name: night_phase_gen

Overview:
- Upstream stage of the streetlight dimming block.
- Debounces the raw 3-bit LDR sensor vector and decides day or night.
- During night, divides time into four phases and drives the downstream block's day[2:0] and TD[1:0] inputs.
- Driven by a slow tick strobe from the system prescaler.

Parameters:
DEBOUNCE, 4, consecutive identical tick samples required before day output updates (2..15)
TICKS_PER_PHASE, 8, ticks per night phase before TD advances (2..65535)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
tick  in  1  one-clk-wide timebase strobe; all counters advance only on clk edges with tick=1
ldr  in  3  raw light-sensor bits, 1 = light detected, asynchronous to nothing (already synchronised)
day  out  3  debounced sensor vector to dimming stage; 3'b111 = full daylight
TD  out  2  night phase index 0..3 to dimming stage
night  out  1  1 while in a night state
phase_pulse  out  1  one-clk pulse when TD increments

Behaviour:
- Reset (rst=0, async, immediate): day=3'b111, TD=2'b00, night=0, phase_pulse=0, state=DAY, internal candidate cand=3'b111, debounce count=DEBOUNCE, phase count=0.
- All logic registered on clk; no combinational paths from inputs to outputs.
- Debounce, evaluated only on tick cycles:
  - ldr!=cand: cand<=ldr, count<=1.
  - ldr==cand and count<DEBOUNCE: count<=count+1; if count+1==DEBOUNCE, day<=cand in the same edge.
  - ldr==cand and count==DEBOUNCE: hold.
  - Net effect: day changes on the edge of the DEBOUNCE-th consecutive matching tick. Shorter glitches never reach day.
- Day/night decision uses registered day only: daylight = (day==3'b111); anything else is night.
- FSM states: DAY, NIGHT_RUN, NIGHT_HOLD.
  - DAY: TD=0, night=0. When day!=3'b111: next edge go to NIGHT_RUN, night<=1, TD<=0, phase count<=0.
  - NIGHT_RUN: on each tick, phase count++. On the tick where count==TICKS_PER_PHASE-1: count<=0, TD<=TD+1, phase_pulse<=1 for exactly one clk. If the new TD==3, go to NIGHT_HOLD.
  - NIGHT_HOLD: TD held at 2'b11, no further pulses. TD saturates and never wraps to 0.
  - Any night state with day==3'b111: next edge go to DAY, TD<=0, night<=0, phase count<=0. This has priority over a coincident phase increment; no phase_pulse is issued that cycle.
- Night-pattern changes (e.g. 101 -> 100) update day but do not restart TD or the phase count.
- tick=0: all counters and state hold. A DAY/night transition still takes effect on the next clk edge after a day change.
- Phase count width: ceil(log2(TICKS_PER_PHASE)). Debounce count width: 4 bits.

Optional Feature:
TD_OVERRIDE_EN
- Defined: adds ports ovr_en (in, 1) and ovr_td (in, 2) for maintenance.
  - While ovr_en=1, TD output = ovr_td registered (1-clk latency) and phase_pulse=0.
  - The FSM and phase counter keep running internally.
  - On release, TD returns to the internal phase value on the next edge.
  - ovr_en is ignored during reset.
- Undefined: ports absent; TD always comes from the FSM.

Test Plan:
- Reset: hold rst=0, ldr=3'b000, tick=1 -> day=111, TD=00, night=0, phase_pulse=0; release and keep ldr=111 for 20 ticks -> no change.
- Dusk (DEBOUNCE=4, TICKS_PER_PHASE=8, tick every clk), ldr 111->101:
  - day=101 on the edge of the 4th tick; night=1 and TD=00 one clk later.
  - TD=01, 10, 11 after 8, 16, 24 further ticks, each with a single phase_pulse.
  - TD stays 11 with no pulses after 100 more ticks.
- Glitch rejection: ldr=101 for 3 ticks, then 111 -> day stays 111, night stays 0, TD=00.
- Dawn mid-night: at TD=10, drive ldr=111 -> day=111 on the 4th tick; TD=00 and night=0 one clk later. Align the dawn with a phase boundary -> no phase_pulse.
- Tick gating and async reset: tick=0 for 50 clks at TD=01 -> TD unchanged. Assert rst=0 mid-cycle in NIGHT_HOLD -> outputs reset before the next clk edge.
- TD_OVERRIDE_EN build: ovr_en=1, ovr_td=10 during DAY -> TD=10 one clk later; drop ovr_en -> TD=00 next clk.
